// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - sequential signed 32-bit Booth multiplier / restoring divider
// Divider, DIV state and sign fixup are present only when MULDIV_DIV_EN is defined.
module mul_div_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_hi,
    output logic [31:0] result_lo,
    output logic        div_by_zero
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [64:0] acc_q, acc_d;
    logic [31:0] m_q, m_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        last;
    logic [32:0] booth_a;
    logic [32:0] booth_sum;
    logic [64:0] booth_next;

    assign last = (cnt_q == 6'd31);

    // A is extended to 33 bits before add/sub so that -2^31 * -2^31 keeps its true sign.
    assign booth_a = {acc_q[64], acc_q[64:33]};
    always_comb begin
        booth_sum = booth_a;
        case (acc_q[1:0])
            2'b01:   booth_sum = booth_a + {m_q[31], m_q};
            2'b10:   booth_sum = booth_a - {m_q[31], m_q};
            default: booth_sum = booth_a;
        endcase
    end
    assign booth_next = {booth_sum, acc_q[32:1]};

`ifdef MULDIV_DIV_EN
    logic        qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic        dbz_q, dbz_d;
    logic [31:0] a_mag, b_mag;
    logic [32:0] div_shift, div_diff;
    logic [64:0] div_next;

    assign a_mag     = a[31] ? (32'd0 - a) : a;
    assign b_mag     = b[31] ? (32'd0 - b) : b;
    // Partial remainder lives in acc[64:32], dividend/quotient bits in acc[31:0].
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_diff  = div_shift - {1'b0, m_q};
    assign div_next  = div_diff[32] ? {div_shift, acc_q[30:0], 1'b0}
                                    : {div_diff, acc_q[30:0], 1'b1};
    assign div_by_zero = dbz_q;
`else
    logic unused_op;
    assign unused_op   = op;
    assign div_by_zero = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
`ifdef MULDIV_DIV_EN
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        dbz_d    = dbz_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    cnt_d   = 6'd0;
                    state_d = S_MUL;
                    acc_d   = {32'd0, b, 1'b0};
                    m_d     = a;
`ifdef MULDIV_DIV_EN
                    if (op) begin
                        qneg_d = a[31] ^ b[31];
                        rneg_d = a[31];
                        m_d    = b_mag;
                        if (b == 32'd0) begin
                            dz_d    = 1'b1;
                            acc_d   = {33'd0, a};
                            state_d = S_FIXUP;
                        end else begin
                            dz_d    = 1'b0;
                            acc_d   = {33'd0, a_mag};
                            state_d = S_DIV;
                        end
                    end
`endif
                end
            end
            S_MUL: begin
                acc_d = booth_next;
                cnt_d = cnt_q + 6'd1;
                if (last) begin
                    state_d  = S_DONE;
                    res_hi_d = booth_next[64:33];
                    res_lo_d = booth_next[32:1];
`ifdef MULDIV_DIV_EN
                    dbz_d    = 1'b0;
`endif
                end
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 6'd1;
                if (last) state_d = S_FIXUP;
            end
            S_FIXUP: begin
                state_d = S_DONE;
                if (dz_q) begin
                    res_hi_d = acc_q[31:0];
                    res_lo_d = 32'hFFFF_FFFF;
                    dbz_d    = 1'b1;
                end else begin
                    res_hi_d = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
                    res_lo_d = qneg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
                    dbz_d    = 1'b0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            acc_q    <= 65'd0;
            m_q      <= 32'd0;
            cnt_q    <= 6'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
`ifdef MULDIV_DIV_EN
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            dbz_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
`ifdef MULDIV_DIV_EN
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            dbz_q    <= dbz_d;
`endif
        end
    end

    assign busy      = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIXUP);
    assign done      = (state_q == S_DONE);
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed-vector bench for mul_div_unit
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        clr, start, op;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] result_hi, result_lo;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] ph, pl;

    mul_div_unit dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0; a = $urandom; b = $urandom; op = ~o;
    endtask

    // Entered at cycle 1; returns in the done cycle with results checked.
    task automatic run(input string tag, input int lat, input logic [31:0] hi, input logic [31:0] lo,
                       input logic dz, input bit inject);
        int n = 1;
        bit busy_ok = 1'b1;
        bit hold_ok = 1'b1;
        while (!done && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (result_hi !== ph || result_lo !== pl) hold_ok = 1'b0;
            if (inject && n == 5) begin
                start = 1'b1; a = 32'd1; b = 32'd1; op = 1'b0;
            end
            step();
            start = 1'b0;
            n++;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " held"}, {31'd0, hold_ok}, 32'd1);
        check({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
        check({tag, " hi"}, result_hi, hi);
        check({tag, " lo"}, result_lo, lo);
        check({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, dz});
        ph = hi; pl = lo;
    endtask

    task automatic abort_check(input logic o);
        bit no_done = 1'b1;
        launch(o, 32'd100, 32'd7);
        for (int i = 0; i < 9; i++) step();
        clr = 1'b0;
        step();
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort hi", result_hi, 32'd0);
        check("abort lo", result_lo, 32'd0);
        check("abort dbz", {31'd0, div_by_zero}, 32'd0);
        clr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) no_done = 1'b0;
        end
        check("abort quiet", {31'd0, no_done}, 32'd1);
        ph = 32'd0; pl = 32'd0;
    endtask

    initial begin
        clr = 1'b0; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
        ph = 32'd0; pl = 32'd0;
        step(); step();
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst hi", result_hi, 32'd0);
        check("rst lo", result_lo, 32'd0);
        check("rst dbz", {31'd0, div_by_zero}, 32'd0);
        clr = 1'b1;
        step();

        launch(1'b0, 32'd7, 32'hFFFF_FFFD);
        run("mul_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
        step();
        check("done_pulse", {31'd0, done}, 32'd0);

        launch(1'b0, 32'h8000_0000, 32'h8000_0000);
        run("mul_min", 33, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
        launch(1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
        check("b2b busy", {31'd0, busy}, 32'd1);
        run("mul_b2b", 33, 32'hFFFF_FFFF, 32'hEDCB_A988, 1'b0, 1'b0);
        step();
        launch(1'b0, 32'h0001_0000, 32'h0001_0000);
        run("mul_pos", 33, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
        step();

`ifdef MULDIV_DIV_EN
        launch(1'b1, 32'hFFFF_FFEF, 32'd5);
        run("div_neg", 34, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0);
        step();
        launch(1'b1, 32'd10, 32'd0);
        run("div_zero", 2, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step();
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run("div_ovf", 34, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        step();
        launch(1'b1, 32'd17, 32'hFFFF_FFFB);
        run("div_negb", 34, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 1'b0);
        step();
        abort_check(1'b1);
`else
        launch(1'b1, 32'd6, 32'd7);
        run("op_ignored", 33, 32'h0000_0000, 32'h0000_002A, 1'b0, 1'b0);
        step();
        abort_check(1'b0);
`endif

        clr = 1'b0; start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd5;
        step();
        check("clr_start busy", {31'd0, busy}, 32'd0);
        clr = 1'b1; start = 1'b0;
        step();
        check("clr_start idle", {30'd0, busy, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
